controle_varredura: RTL and testbench

- Sequencer for the external saturating up/down position counter (vai/vem/zera_s datapath with fim/Q outputs).
- Issues timed single-cycle vai and vem step pulses to sweep the counter from 0 up to its top (fim) and back down to 0.
- Repeats the round trip CICLOS times, or without limit in continuous mode.
- Supports pause and abort; sits between the top-level control unit and the counter.

---
 rtl/controle_varredura.sv | 131 +++++++++++++
 tb/tb_controle_varredura.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/controle_varredura.sv
// rtl/controle_varredura.sv - sweep sequencer driving an external saturating up/down position counter
// Steps the counter 0 -> top -> 0 with timed vai/vem pulses, CICLOS times or continuously.
module controle_varredura #(
  parameter int N           = 7,
  parameter int TICK_CYCLES = 50,
  parameter int CICLOS      = 3,
  parameter int CW          = 4
) (
  input  logic          clock,
  input  logic          zera_as_n,
  input  logic          iniciar,
  input  logic          pausar,
  input  logic          parar,
  input  logic          modo_continuo,
  input  logic          fim,
  input  logic [N-1:0]  q,
  output logic          vai,
  output logic          vem,
  output logic          zera_s,
  output logic          direcao,
  output logic          ocupado,
  output logic          pronto,
  output logic [CW-1:0] voltas,
  output logic [3:0]    db_estado
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_FIM  = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] VOLTAS_FIM = CW'(CICLOS);

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    PREPARA      = 4'd1,
    ESPERA_SOBE  = 4'd2,
    SOBE         = 4'd3,
    ESPERA_DESCE = 4'd4,
    DESCE        = 4'd5,
    FINAL        = 4'd7
  } estado_t;

  estado_t       estado, prox_estado;
  logic [TW-1:0] timer, prox_timer;
  logic [CW-1:0] voltas_r, prox_voltas;
  logic          dir_r, prox_dir;
  logic [CW-1:0] voltas_inc;

  assign voltas_inc = voltas_r + 1'b1;

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      estado   <= OCIOSO;
      timer    <= '0;
      voltas_r <= '0;
      dir_r    <= 1'b0;
    end else begin
      estado   <= prox_estado;
      timer    <= prox_timer;
      voltas_r <= prox_voltas;
      dir_r    <= prox_dir;
    end
  end

  always_comb begin
    prox_estado = estado;
    prox_timer  = timer;
    prox_voltas = voltas_r;
    prox_dir    = dir_r;
    // Abort beats pause and the end-of-travel checks; counter, voltas and direction are left as they are.
    if (parar && estado != OCIOSO) begin
      prox_estado = OCIOSO;
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            prox_estado = PREPARA;
            prox_voltas = '0;
            prox_dir    = 1'b0;
            prox_timer  = '0;
          end
        end
        PREPARA: prox_estado = ESPERA_SOBE;
        ESPERA_SOBE: begin
          if (fim) begin
            prox_estado = ESPERA_DESCE;
            prox_timer  = '0;
            prox_dir    = 1'b1;
          end else if (!pausar) begin
            if (timer == TIMER_FIM) prox_estado = SOBE;
            else                    prox_timer  = timer + 1'b1;
          end
        end
        SOBE: begin
          prox_timer  = '0;
          prox_estado = ESPERA_SOBE;
        end
        ESPERA_DESCE: begin
          if (q == '0) begin
            prox_voltas = voltas_inc;
            if (!modo_continuo && voltas_inc == VOLTAS_FIM) begin
              prox_estado = FINAL;
            end else begin
              prox_estado = ESPERA_SOBE;
              prox_dir    = 1'b0;
              prox_timer  = '0;
            end
          end else if (!pausar) begin
            if (timer == TIMER_FIM) prox_estado = DESCE;
            else                    prox_timer  = timer + 1'b1;
          end
        end
        DESCE: begin
          prox_timer  = '0;
          prox_estado = ESPERA_DESCE;
        end
        FINAL:   prox_estado = OCIOSO;
        default: prox_estado = OCIOSO;
      endcase
    end
  end

  // Moore decode: each pulse belongs to exactly one state, so they can never overlap.
  assign vai       = (estado == SOBE);
  assign vem       = (estado == DESCE);
  assign zera_s    = (estado == PREPARA);
  assign pronto    = (estado == FINAL);
  assign ocupado   = (estado != OCIOSO);
  assign direcao   = dir_r;
  assign voltas    = voltas_r;
  assign db_estado = estado;

endmodule

// File: tb/tb_controle_varredura.sv
// tb/tb_controle_varredura.sv - directed self-checking bench for controle_varredura
// Drives an 8-position saturating counter model (N=3) with TICK_CYCLES=4, CICLOS=2.
module tb_controle_varredura;

  localparam int N    = 3;
  localparam int TICK = 4;
  localparam int CIC  = 2;
  localparam int CW   = 4;

  logic          clock = 1'b0;
  logic          zera_as_n = 1'b0;
  logic          iniciar = 1'b0;
  logic          pausar = 1'b0;
  logic          parar = 1'b0;
  logic          modo_continuo = 1'b0;
  logic          fim;
  logic [N-1:0]  q = '0;
  logic          vai, vem, zera_s, direcao, ocupado, pronto;
  logic [CW-1:0] voltas;
  logic [3:0]    db_estado;

  int checks = 0;
  int errors = 0;
  int j, n_vai, n_vem, n_zs, n_pronto, n_overlap, n_sat, n_dir, n_ocup, pronto_j, prev;
  int vai_j[$];
  int vem_j[$];

  controle_varredura #(.N(N), .TICK_CYCLES(TICK), .CICLOS(CIC), .CW(CW)) dut (
    .clock(clock), .zera_as_n(zera_as_n), .iniciar(iniciar), .pausar(pausar),
    .parar(parar), .modo_continuo(modo_continuo), .fim(fim), .q(q),
    .vai(vai), .vem(vem), .zera_s(zera_s), .direcao(direcao), .ocupado(ocupado),
    .pronto(pronto), .voltas(voltas), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // External counter: M=8, saturating, no link to the sequencer reset.
  always @(posedge clock) begin
    if (zera_s)                q <= '0;
    else if (vai && q != 3'd7) q <= q + 3'd1;
    else if (vem && q != 3'd0) q <= q - 3'd1;
  end
  assign fim = (q == 3'd7);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  task automatic clear_stats();
    j = 0; n_vai = 0; n_vem = 0; n_zs = 0; n_pronto = 0; n_overlap = 0;
    n_sat = 0; n_dir = 0; n_ocup = 0; pronto_j = -1;
    vai_j.delete();
    vem_j.delete();
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    j++;
    if (vai) begin n_vai++; vai_j.push_back(j); end
    if (vem) begin n_vem++; vem_j.push_back(j); end
    if (zera_s) n_zs++;
    if (pronto) begin n_pronto++; pronto_j = j; end
    if (int'(vai) + int'(vem) + int'(zera_s) > 1) n_overlap++;
    if ((vai && q == 3'd7) || (vem && q == 3'd0)) n_sat++;
    if ((vai && direcao) || (vem && !direcao)) n_dir++;
    if (!ocupado) n_ocup++;
  endtask

  // iniciar is sampled at edge k; on return j=0 is the cycle right after edge k.
  task automatic start();
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    clear_stats();
  endtask

  initial begin
    clear_stats();
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", db_estado, 0);
    check("rst_pulses", {vai, vem, zera_s, pronto, ocupado}, 0);
    check("rst_voltas", voltas, 0);
    zera_as_n = 1'b1;
    repeat (3) step();
    check("idle_no_start", db_estado, 0);

    // Full two-trip sweep
    start();
    check("zera_s_k1", zera_s, 1);
    check("prepara_state", db_estado, 1);
    while (db_estado != 0 && j < 400) step();
    check("sweep_ends_idle", db_estado, 0);
    check("vai_first", at(vai_j, 0), 5);
    check("vai_second", at(vai_j, 1), 10);
    check("vai_seventh", at(vai_j, 6), 35);
    check("vem_first", at(vem_j, 0), 41);
    check("vem_spacing", at(vem_j, 1), 46);
    check("vai_total", n_vai, 14);
    check("vem_total", n_vem, 14);
    check("pronto_once", n_pronto, 1);
    check("pronto_cycle", pronto_j, 145);
    check("voltas_final", voltas, CIC);
    check("q_final", q, 0);
    check("no_saturate", n_sat, 0);
    check("dir_consistent", n_dir, 0);
    check("overlap_sweep", n_overlap, 0);

    // Pause inside ESPERA_SOBE, then abort after the third vai
    start();
    while (j < 6) step();
    check("pre_pause_state", db_estado, 2);
    pausar = 1'b1;
    repeat (10) step();
    pausar = 1'b0;
    check("pause_no_pulse", n_vai + n_vem, 1);
    check("pause_ocupado", n_ocup, 0);
    while (n_vai < 3 && j < 60) step();
    check("vai2_delayed", at(vai_j, 1), 20);
    check("vai3", at(vai_j, 2), 25);
    step();
    check("q_before_abort", q, 3);
    parar = 1'b1;
    step();
    parar = 1'b0;
    check("abort_idle", db_estado, 0);
    clear_stats();
    repeat (30) step();
    check("abort_no_pulse", n_vai + n_vem + n_zs + n_pronto, 0);
    check("abort_q_hold", q, 3);
    check("abort_voltas", voltas, 0);
    start();
    check("restart_zera_s", zera_s, 1);
    step();
    check("restart_q0", q, 0);
    check("restart_state", db_estado, 2);
    parar = 1'b1;
    step();
    parar = 1'b0;

    // Continuous mode for five round trips
    modo_continuo = 1'b1;
    start();
    prev = 0;
    while (voltas != 4'd5 && j < 1000) begin
      step();
      if (int'(voltas) != prev) begin
        check("cont_voltas_seq", voltas, prev + 1);
        prev = voltas;
      end
    end
    check("cont_voltas5", voltas, 5);
    check("cont_at_trip5", j, 361);
    check("cont_no_pronto", n_pronto, 0);
    check("cont_overlap", n_overlap, 0);

    // Asynchronous reset while in SOBE
    while (!vai && j < 1100) step();
    check("sobe_reached", db_estado, 3);
    zera_as_n = 1'b0;
    #1;
    check("rst_vai_async", vai, 0);
    check("rst_async_state", db_estado, 0);
    #2;
    zera_as_n = 1'b1;
    step();
    check("post_rst_state", db_estado, 0);
    check("post_rst_voltas", voltas, 0);
    check("post_rst_ocupado", ocupado, 0);
    clear_stats();
    repeat (20) step();
    check("post_rst_quiet", n_vai + n_vem + n_zs + n_pronto, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
